// File: rtl/fpu_minmax_opstage.sv
// fpu_minmax_opstage: registered operand-preparation stage ahead of the
// single-precision FMIN.S/FMAX.S compare. Screens operands for NaN following
// the RISC-V F rules, precomputes a bypass result where the compare must not
// decide, raises NV on signalling NaNs, and buffers through a 2-entry skid
// buffer so in_ready_o comes straight from a flop.
// Optional build macro: FPU_MINMAX_OPSTAGE_PERF_EN adds three 32-bit
// performance counters (ops, NaN bypasses, output stall cycles).
`timescale 1ns/1ps

module fpu_minmax_opstage #(
  parameter logic [31:0] CANON_NAN = 32'h7FC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
  output logic [31:0] perf_ops_o,
  output logic [31:0] perf_nan_o,
  output logic [31:0] perf_stall_o,
`endif
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_is_max_i,
  input  logic [31:0] in_rs1_i,
  input  logic [31:0] in_rs2_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rs1_o,
  output logic [31:0] out_rs2_o,
  output logic        out_mode_o,
  output logic        out_bypass_o,
  output logic [31:0] out_bypass_val_o,
  output logic        out_nv_o
);

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        mode;
    logic        bypass;
    logic [31:0] bval;
    logic        nv;
  } entry_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // A NaN with the quiet bit clear is signalling.
  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  entry_t in_ent;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   xfer_in, drain;
  logic   nan1, nan2;

  assign in_ready_o = ~skid_valid_q;
  assign xfer_in    = in_valid_i & ~skid_valid_q;
  assign drain      = main_valid_q & out_ready_i;

  // Decode the incoming request into a fully prepared entry.
  always_comb begin
    nan1          = is_nan(in_rs1_i);
    nan2          = is_nan(in_rs2_i);
    in_ent        = '0;
    in_ent.rs1    = in_rs1_i;
    in_ent.rs2    = in_rs2_i;
    in_ent.mode   = ~in_is_max_i;
    in_ent.nv     = is_snan(in_rs1_i) | is_snan(in_rs2_i);
    in_ent.bypass = nan1 | nan2;
    if (nan1 && nan2) begin
      in_ent.bval = CANON_NAN;
    end else if (nan1) begin
      in_ent.bval = in_rs2_i;
    end else if (nan2) begin
      in_ent.bval = in_rs1_i;
    end else begin
      in_ent.bval = 32'd0;
    end
  end

  // Skid-buffer next state: skid always refills main first, so order is FIFO.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      // in_ready_o is low here, so nothing new can arrive this cycle.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      main_valid_d = xfer_in;
      if (xfer_in) begin
        main_d = in_ent;
      end
    end else if (xfer_in) begin
      skid_d       = in_ent;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; data is cleared too so outputs read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid_o      = main_valid_q;
  assign out_rs1_o        = main_q.rs1;
  assign out_rs2_o        = main_q.rs2;
  assign out_mode_o       = main_q.mode;
  assign out_bypass_o     = main_q.bypass;
  assign out_bypass_val_o = main_q.bval;
  assign out_nv_o         = main_q.nv;

`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
  logic [31:0] perf_ops_q, perf_nan_q, perf_stall_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_ops_q   <= 32'd0;
      perf_nan_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (xfer_in) begin
        perf_ops_q <= perf_ops_q + 32'd1;
      end
      if (xfer_in && in_ent.bypass) begin
        perf_nan_q <= perf_nan_q + 32'd1;
      end
      if (main_valid_q && !out_ready_i) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_ops_o   = perf_ops_q;
  assign perf_nan_o   = perf_nan_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpu_minmax_opstage.sv
// Self-checking bench for fpu_minmax_opstage: directed NaN/handshake vectors,
// a randomized valid/ready run against an in-order model, and a mid-flight reset.
`timescale 1ns/1ps

module tb_fpu_minmax_opstage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_max;
  logic [31:0] in_rs1, in_rs2;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1, out_rs2, out_bval;
  logic        out_mode, out_bypass, out_nv;
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
  logic [31:0] perf_ops, perf_nan, perf_stall;
`endif

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        mode;
    logic        bypass;
    logic [31:0] bval;
    logic        nv;
  } ent_t;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fpu_minmax_opstage dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
    .perf_ops_o       (perf_ops),
    .perf_nan_o       (perf_nan),
    .perf_stall_o     (perf_stall),
`endif
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_is_max_i      (in_is_max),
    .in_rs1_i         (in_rs1),
    .in_rs2_i         (in_rs2),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_rs1_o        (out_rs1),
    .out_rs2_o        (out_rs2),
    .out_mode_o       (out_mode),
    .out_bypass_o     (out_bypass),
    .out_bypass_val_o (out_bval),
    .out_nv_o         (out_nv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic mode, input logic byp, input logic [31:0] bval,
                            input logic nv);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_rs1"}, out_rs1, a);
    check({tag, "_rs2"}, out_rs2, b);
    check({tag, "_flags"}, {29'd0, out_mode, out_bypass, out_nv}, {29'd0, mode, byp, nv});
    check({tag, "_bval"}, out_bval, bval);
  endtask

  function automatic logic nan_f(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic ent_t model(input logic is_max, input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    e.rs1    = a;
    e.rs2    = b;
    e.mode   = !is_max;
    e.nv     = (nan_f(a) && !a[22]) || (nan_f(b) && !b[22]);
    e.bypass = nan_f(a) || nan_f(b);
    e.bval   = (nan_f(a) && nan_f(b)) ? 32'h7FC0_0000 :
               nan_f(a) ? b : nan_f(b) ? a : 32'd0;
    return e;
  endfunction

  task automatic drive(input logic is_max, input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    in_is_max = is_max;
    in_rs1    = a;
    in_rs2    = b;
  endtask

  logic [31:0] pool [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'h7FC0_0000, 32'h7F80_0001,
                            32'hFFC0_0123, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    ent_t q[$];
    ent_t exp_e, held;
    logic hold_chk;
    int   sent, cyc, nan_cnt, stall_cnt;

    rst_n = 1'b0; in_valid = 1'b0; in_is_max = 1'b0;
    in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ovalid", 32'(out_valid), 32'd0);
    check("rst_iready", 32'(in_ready), 32'd1);
    check("rst_rs1", out_rs1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed decode vectors, one per cycle with the sink always ready.
    out_ready = 1'b1;
    drive(1'b0, 32'h3F80_0000, 32'h4000_0000);
    @(negedge clk); in_valid = 1'b0;
    expect_out("ord", 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, 32'd0, 1'b0);
    drive(1'b1, 32'h7FC0_0000, 32'hC0A0_0000);
    @(negedge clk); in_valid = 1'b0;
    expect_out("qnan1", 32'h7FC0_0000, 32'hC0A0_0000, 1'b0, 1'b1, 32'hC0A0_0000, 1'b0);
    drive(1'b0, 32'h7F80_0001, 32'h7FC0_0001);
    @(negedge clk); in_valid = 1'b0;
    expect_out("bothnan", 32'h7F80_0001, 32'h7FC0_0001, 1'b1, 1'b1, 32'h7FC0_0000, 1'b1);
    drive(1'b1, 32'h3F80_0000, 32'hFF80_0001);
    @(negedge clk); in_valid = 1'b0;
    expect_out("snan2", 32'h3F80_0000, 32'hFF80_0001, 1'b0, 1'b1, 32'h3F80_0000, 1'b1);
    drive(1'b0, 32'h7F80_0000, 32'hFF80_0000);
    @(negedge clk); in_valid = 1'b0;
    expect_out("inf", 32'h7F80_0000, 32'hFF80_0000, 1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("dir_empty", 32'(out_valid), 32'd0);
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
    check("perf_ops_dir", perf_ops, 32'd5);
    check("perf_nan_dir", perf_nan, 32'd3);
    check("perf_stall_dir", perf_stall, 32'd0);
`endif

    // Back-to-back A, B, C with the sink stalled.
    out_ready = 1'b0;
    drive(1'b0, 32'h0000_00A1, 32'h0000_00A2);
    @(negedge clk);
    check("b2b_rdy_after_a", 32'(in_ready), 32'd1);
    drive(1'b0, 32'h0000_00B1, 32'h0000_00B2);
    @(negedge clk);
    check("b2b_rdy_after_b", 32'(in_ready), 32'd0);
    check("b2b_head_a", out_rs1, 32'h0000_00A1);
    drive(1'b1, 32'h0000_00C1, 32'h0000_00C2);
    @(negedge clk);
    check("b2b_still_full", 32'(in_ready), 32'd0);
    check("b2b_hold_a", out_rs1, 32'h0000_00A1);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_head_b", out_rs1, 32'h0000_00B1);
    check("b2b_rdy_back", 32'(in_ready), 32'd1);
    @(negedge clk); in_valid = 1'b0;
    expect_out("b2b_c", 32'h0000_00C1, 32'h0000_00C2, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("b2b_empty", 32'(out_valid), 32'd0);
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
    check("perf_ops_b2b", perf_ops, 32'd8);
    check("perf_stall_b2b", perf_stall, 32'd2);
`endif

    // Randomized valid/ready traffic against an in-order model.
    sent = 0; cyc = 0; nan_cnt = 0; stall_cnt = 0; hold_chk = 1'b0; held = '0;
    while (!(sent == 100 && q.size() == 0) && cyc < 3000) begin
      check("rnd_ovalid", 32'(out_valid), 32'(q.size() > 0));
      check("rnd_iready", 32'(in_ready), 32'(q.size() < 2));
      if (hold_chk) begin
        check("rnd_stable", {out_rs1 ^ held.rs1} | {out_rs2 ^ held.rs2} | {out_bval ^ held.bval}
              | {29'd0, out_mode ^ held.mode, out_bypass ^ held.bypass, out_nv ^ held.nv}, 32'd0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 100 && $urandom_range(0, 3) != 0) drive(1'($urandom_range(0, 1)), pick(), pick());
      else in_valid = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("rnd_dup", 32'd1, 32'd0);
        end else begin
          exp_e = q.pop_front();
          check("rnd_rs1", out_rs1, exp_e.rs1);
          check("rnd_rs2", out_rs2, exp_e.rs2);
          check("rnd_flags", {29'd0, out_mode, out_bypass, out_nv},
                {29'd0, exp_e.mode, exp_e.bypass, exp_e.nv});
          check("rnd_bval", out_bval, exp_e.bval);
        end
      end
      hold_chk = out_valid && !out_ready;
      if (hold_chk) begin
        stall_cnt++;
        held = '{out_rs1, out_rs2, out_mode, out_bypass, out_bval, out_nv};
      end
      if (in_valid && in_ready) begin
        exp_e = model(in_is_max, in_rs1, in_rs2);
        q.push_back(exp_e);
        sent++;
        if (exp_e.bypass) nan_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rnd_done", 32'(sent == 100 && q.size() == 0), 32'd1);
    in_valid = 1'b0;
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
    check("perf_ops_rnd", perf_ops, 32'(108));
    check("perf_nan_rnd", perf_nan, 32'(3 + nan_cnt));
    check("perf_stall_rnd", perf_stall, 32'(2 + stall_cnt));
`endif

    // Fill both slots, then reset mid-flight.
    out_ready = 1'b0;
    drive(1'b0, 32'h1234_5678, 32'h7F80_0001);
    @(negedge clk);
    drive(1'b1, 32'h4040_0000, 32'h4080_0000);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst2_full", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst2_ovalid", 32'(out_valid), 32'd0);
    check("rst2_iready", 32'(in_ready), 32'd1);
    check("rst2_data", out_rs1 | out_rs2 | out_bval, 32'd0);
    check("rst2_flags", {29'd0, out_mode, out_bypass, out_nv}, 32'd0);
`ifdef FPU_MINMAX_OPSTAGE_PERF_EN
    check("rst2_perf", perf_ops | perf_nan | perf_stall, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst2_no_stale", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
